// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin arbiter + sequencer sharing one pipelined signed
// multiply-accumulate unit among NUM_REQ burst requesters (FIR-style dot
// products). A requester owns the MAC for a whole burst; the Q(FRAC_BITS)
// scaled, rounded and saturated result is returned tagged with its index.
//
// Ports:
//   clk_i, reset_ni        clock, async active-low reset
//   valid_i/last_i [R]     per-requester beat valid / final-beat flag
//   a_i/b_i [R*NB]         packed signed data / coefficient, lane k at [k*NB +: NB]
//   ready_o [R]            beat accepted when valid_i[k] & ready_o[k]
//   grant_o [R]            one-hot MAC owner, zero when idle
//   result_o [NB]          rounded, saturated dot product (held until next)
//   result_id_o [IW]       owner index of result_o
//   result_valid_o         one-cycle result strobe
//   busy_o                 FSM not idle

// Per-lane gating: ready decode and AND-mask of the lane's beat so the top
// can OR-reduce all lanes into a single MAC operand set.
module mac_arbiter_lane #(
  parameter int NUM_BITS = 24
) (
  input  logic                burst_i,
  input  logic                gnt_i,
  input  logic                valid_i,
  input  logic                last_i,
  input  logic [NUM_BITS-1:0] a_i,
  input  logic [NUM_BITS-1:0] b_i,
  output logic                ready_o,
  output logic                acc_o,
  output logic                last_o,
  output logic [NUM_BITS-1:0] a_o,
  output logic [NUM_BITS-1:0] b_o
);
  assign ready_o = burst_i & gnt_i;
  assign acc_o   = ready_o & valid_i;
  assign last_o  = acc_o & last_i;
  assign a_o     = {NUM_BITS{gnt_i}} & a_i;
  assign b_o     = {NUM_BITS{gnt_i}} & b_i;
endmodule

module mac_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_BITS  = 24,
  parameter  int ACC_BITS  = 56,
  parameter  int FRAC_BITS = 23,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [NUM_REQ-1:0]          valid_i,
  input  logic [NUM_REQ-1:0]          last_i,
  input  logic [NUM_REQ*NUM_BITS-1:0] a_i,
  input  logic [NUM_REQ*NUM_BITS-1:0] b_i,
  output logic [NUM_REQ-1:0]          ready_o,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [NUM_BITS-1:0]         result_o,
  output logic [IW-1:0]               result_id_o,
  output logic                        result_valid_o,
  output logic                        busy_o
);
  localparam int PW = 2 * NUM_BITS;
  localparam logic [ACC_BITS-1:0] ACC_ONE = {{(ACC_BITS-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_BITS-1:0] RND_HALF = ACC_ONE << (FRAC_BITS - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_MAX  = (ACC_ONE << (NUM_BITS - 1)) - ACC_ONE;
  localparam logic signed [ACC_BITS-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_BURST, S_DRAIN, S_OUT} state_t;

  typedef struct packed {
    logic                vld;
    logic                last;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
  } beat_t;

  state_t                    state_q, state_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic [IW-1:0]             gidx_q, gidx_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic                      first_q, first_d;
  logic [1:0]                vld_pipe_q, vld_pipe_d;   // [0]=stage1 full, [1]=acc took a product
  logic signed [PW-1:0]      p_q, p_d;
  logic                      p_first_q, p_first_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic [NUM_BITS-1:0]       result_q, result_d;
  logic [IW-1:0]             result_id_q, result_id_d;
  logic                      result_valid_q, result_valid_d;

  // lanes
  logic                              in_burst;
  logic [NUM_REQ-1:0]                lane_rdy, lane_acc, lane_last;
  logic [NUM_REQ-1:0][NUM_BITS-1:0]  lane_a, lane_b;
  beat_t                             beat;

  assign in_burst = (state_q == S_BURST);

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    mac_arbiter_lane #(.NUM_BITS(NUM_BITS)) u_lane (
      .burst_i (in_burst),
      .gnt_i   (grant_q[k]),
      .valid_i (valid_i[k]),
      .last_i  (last_i[k]),
      .a_i     (a_i[k*NUM_BITS +: NUM_BITS]),
      .b_i     (b_i[k*NUM_BITS +: NUM_BITS]),
      .ready_o (lane_rdy[k]),
      .acc_o   (lane_acc[k]),
      .last_o  (lane_last[k]),
      .a_o     (lane_a[k]),
      .b_o     (lane_b[k])
    );
  end

  // Grant is one-hot, so OR-reduction is the operand mux.
  always_comb begin
    beat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      beat.vld  = beat.vld  | lane_acc[k];
      beat.last = beat.last | lane_last[k];
      beat.a    = beat.a    | lane_a[k];
      beat.b    = beat.b    | lane_b[k];
    end
  end

  // Round-robin pick: first valid requester at or after ptr+1.
  logic [NUM_REQ-1:0] sel_oh;
  logic [IW-1:0]      sel_idx;
  logic               sel_found;

  always_comb begin
    sel_oh    = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int j;
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (!sel_found && valid_i[IW'(j)]) begin
        sel_found       = 1'b1;
        sel_idx         = IW'(j);
        sel_oh          = '0;
        sel_oh[IW'(j)]  = 1'b1;
      end
    end
  end

  // MAC datapath
  logic signed [PW-1:0]       a_x, b_x, prod;
  logic signed [ACC_BITS-1:0] p_x, rnd, rnd_sh;
  logic [NUM_BITS-1:0]        rnd_sat;

  always_comb begin
    a_x  = {{NUM_BITS{beat.a[NUM_BITS-1]}}, beat.a};
    b_x  = {{NUM_BITS{beat.b[NUM_BITS-1]}}, beat.b};
    prod = a_x * b_x;
    p_x  = {{(ACC_BITS-PW){p_q[PW-1]}}, p_q};

    vld_pipe_d = {vld_pipe_q[0], beat.vld};
    p_d        = beat.vld ? prod : p_q;
    p_first_d  = beat.vld ? first_q : p_first_q;
    acc_d      = acc_q;
    if (vld_pipe_q[0]) acc_d = p_first_q ? p_x : (acc_q + p_x);

    rnd    = acc_q + RND_HALF;
    rnd_sh = rnd >>> FRAC_BITS;
    if (rnd_sh > SAT_MAX)      rnd_sat = SAT_MAX[NUM_BITS-1:0];
    else if (rnd_sh < SAT_MIN) rnd_sat = SAT_MIN[NUM_BITS-1:0];
    else                       rnd_sat = rnd_sh[NUM_BITS-1:0];
  end

  // Drain is complete once stage 1 is empty and acc absorbed the final product.
  logic drain_done;
  assign drain_done = (vld_pipe_q == 2'b10);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    ptr_d          = ptr_q;
    first_d        = first_q;
    result_d       = result_q;
    result_id_d    = result_id_q;
    result_valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (sel_found) begin
        grant_d = sel_oh;
        gidx_d  = sel_idx;
        state_d = S_GRANT;
      end
      S_GRANT: begin
        first_d = 1'b1;
        state_d = S_BURST;
      end
      S_BURST: if (beat.vld) begin
        first_d = 1'b0;
        if (beat.last) state_d = S_DRAIN;
      end
      S_DRAIN: if (drain_done) begin
        result_d       = rnd_sat;
        result_id_d    = gidx_q;
        ptr_d          = gidx_q;
        result_valid_d = 1'b1;
        state_d        = S_OUT;
      end
      S_OUT: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      gidx_q         <= '0;
      ptr_q          <= IW'(NUM_REQ - 1);
      first_q        <= 1'b0;
      vld_pipe_q     <= '0;
      p_q            <= '0;
      p_first_q      <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_id_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      gidx_q         <= gidx_d;
      ptr_q          <= ptr_d;
      first_q        <= first_d;
      vld_pipe_q     <= vld_pipe_d;
      p_q            <= p_d;
      p_first_q      <= p_first_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_id_q    <= result_id_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign ready_o        = lane_rdy;
  assign grant_o        = grant_q;
  assign result_o       = result_q;
  assign result_id_o    = result_id_q;
  assign result_valid_o = result_valid_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: per-requester beat queues driven on the
// falling edge, outputs observed on the falling edge, hand-computed results.
module tb_mac_arbiter;
  localparam int N  = 4;
  localparam int NB = 24;
  localparam int IW = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  valid = '0, last = '0;
  logic [N*NB-1:0] a = '0, b = '0;
  logic [N-1:0]  ready, grant;
  logic [NB-1:0] res;
  logic [IW-1:0] rid;
  logic          rv, busy;

  always #5 clk = ~clk;

  mac_arbiter #(.NUM_REQ(N), .NUM_BITS(NB), .ACC_BITS(56), .FRAC_BITS(23)) dut (
    .clk_i(clk), .reset_ni(rst_n), .valid_i(valid), .last_i(last),
    .a_i(a), .b_i(b), .ready_o(ready), .grant_o(grant), .result_o(res),
    .result_id_o(rid), .result_valid_o(rv), .busy_o(busy)
  );

  typedef struct { bit bub; bit lst; int av; int bv; } beat_t;
  beat_t q[N][$];
  bit    pend[N];
  int    acc_cnt[N], acc_step[N], gnt_first[N], rdy_first[N];
  int    step_n = 0;
  int    res_v[$], res_id[$], res_step[$], gnt_ord[$];
  logic [N-1:0] gnt_prev = '0;
  int    viol = 0;
  int    n_tests = 0, n_fail = 0;

  task automatic chk(string tag, longint obs, longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic push(int k, int av, int bv, bit lst);
    beat_t e;
    e.bub = 1'b0; e.lst = lst; e.av = av; e.bv = bv;
    q[k].push_back(e);
  endtask

  task automatic push_bub(int k, int n);
    beat_t e;
    e.bub = 1'b1; e.lst = 1'b0; e.av = 0; e.bv = 0;
    repeat (n) q[k].push_back(e);
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (q[k].size() != 0 || pend[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic trk_clr();
    res_v.delete(); res_id.delete(); res_step.delete(); gnt_ord.delete();
    viol = 0;
    gnt_prev = grant;
    for (int k = 0; k < N; k++) begin
      gnt_first[k] = -1; rdy_first[k] = -1; acc_cnt[k] = 0; acc_step[k] = -1;
    end
  endtask

  // One cycle: observe this cycle's outputs, then present the next beats.
  task automatic step();
    @(negedge clk);
    step_n++;
    if (rv) begin
      res_v.push_back(int'($signed(res)));
      res_id.push_back(int'(rid));
      res_step.push_back(step_n);
    end
    if (grant != '0 && grant != gnt_prev)
      for (int k = 0; k < N; k++) if (grant[k]) gnt_ord.push_back(k);
    gnt_prev = grant;
    if ((ready & ~grant) != '0 || $countones(grant) > 1) viol++;
    for (int k = 0; k < N; k++) begin
      if (grant[k] && gnt_first[k] < 0) gnt_first[k] = step_n;
      if (ready[k] && rdy_first[k] < 0) rdy_first[k] = step_n;
      if (pend[k]) begin void'(q[k].pop_front()); pend[k] = 1'b0; end
      valid[k] = 1'b0; last[k] = 1'b0;
      a[k*NB +: NB] = '0; b[k*NB +: NB] = '0;
      if (q[k].size() > 0) begin
        if (q[k][0].bub) pend[k] = 1'b1;
        else begin
          valid[k] = 1'b1;
          last[k]  = q[k][0].lst;
          a[k*NB +: NB] = NB'(q[k][0].av);
          b[k*NB +: NB] = NB'(q[k][0].bv);
          if (ready[k]) begin pend[k] = 1'b1; acc_cnt[k]++; acc_step[k] = step_n; end
        end
      end
    end
  endtask

  task automatic run(string tag, int budget);
    bit done = 1'b0;
    repeat (budget) begin
      step();
      if (all_empty() && !busy) begin done = 1'b1; break; end
    end
    chk({tag, "_timeout"}, done, 1);
  endtask

  function automatic int qget(int qq[$], int i);
    return (i < qq.size()) ? qq[i] : -999;
  endfunction

  initial begin
    int s0;
    bit hit;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    trk_clr();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_ready", ready, 0);
    chk("rst_result", res, 0);
    chk("rst_id", rid, 0);
    chk("rst_rv", rv, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // single beat, unity gain, latency
    trk_clr();
    s0 = step_n + 1;
    push(0, 1000, 8388607, 1);
    run("t1", 40);
    chk("t1_nres", res_v.size(), 1);
    chk("t1_val", qget(res_v, 0), 1000);
    chk("t1_id", qget(res_id, 0), 0);
    chk("t1_lat", qget(res_step, 0) - acc_step[0], 3);
    chk("t1_gnt_lat", gnt_first[0] - s0, 1);
    chk("t1_rdy_lat", rdy_first[0] - s0, 2);
    chk("t1_hold", $signed(res), 1000);

    // multi-beat signed
    trk_clr();
    push(2, 4096, 4194304, 0);
    push(2, -2048, 4194304, 0);
    push(2, 100, 8388607, 1);
    run("t2", 40);
    chk("t2_val", qget(res_v, 0), 1124);
    chk("t2_id", qget(res_id, 0), 2);
    chk("t2_beats", acc_cnt[2], 3);

    // saturation both ways
    trk_clr();
    for (int i = 0; i < 4; i++) push(1, 8388607, 8388607, i == 3);
    run("t3p", 40);
    chk("t3_pos", qget(res_v, 0), 8388607);
    chk("t3_pos_id", qget(res_id, 0), 1);
    trk_clr();
    for (int i = 0; i < 4; i++) push(3, -8388608, 8388607, i == 3);
    run("t3n", 40);
    chk("t3_neg", qget(res_v, 0), -8388608);
    chk("t3_neg_id", qget(res_id, 0), 3);

    // fairness: all four with two 2-beat bursts each
    trk_clr();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 4; i++) push(k, 100 * (k + 1), 8388607, i[0]);
    run("t4", 200);
    chk("t4_ngnt", gnt_ord.size(), 8);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_gnt%0d", i), qget(gnt_ord, i), i % 4);
    chk("t4_nres", res_v.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_id%0d", i), qget(res_id, i), i % 4);
      chk($sformatf("t4_val%0d", i), qget(res_v, i), 200 * (i % 4 + 1));
    end
    chk("t4_rdy_excl", viol, 0);

    // bubbles: no preemption while requester 1 waits
    trk_clr();
    push(0, 1000, 8388607, 0);
    push_bub(0, 5);
    push(0, 2000, 8388607, 1);
    push(1, 500, 8388607, 1);
    run("t5", 80);
    chk("t5_ngnt", gnt_ord.size(), 2);
    chk("t5_gnt0", qget(gnt_ord, 0), 0);
    chk("t5_gnt1", qget(gnt_ord, 1), 1);
    chk("t5_val0", qget(res_v, 0), 3000);
    chk("t5_id0", qget(res_id, 0), 0);
    chk("t5_val1", qget(res_v, 1), 500);
    chk("t5_id1", qget(res_id, 1), 1);
    chk("t5_rdy_excl", viol, 0);

    // reset during the 2nd beat of requester 2's burst
    trk_clr();
    for (int i = 0; i < 4; i++) push(2, 1000, 8388607, i == 3);
    hit = 1'b0;
    repeat (50) begin
      step();
      if (pend[2] && acc_cnt[2] == 2) begin hit = 1'b1; break; end
    end
    chk("t6_reach", hit, 1);
    chk("t6_pre_gnt", qget(gnt_ord, 0), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_ready", ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rv", rv, 0);
    chk("t6_result", res, 0);
    chk("t6_id", rid, 0);
    for (int k = 0; k < N; k++) begin q[k].delete(); pend[k] = 1'b0; end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("t6_no_rv", res_v.size(), 0);
    trk_clr();
    push(2, 300, 8388607, 1);
    push(0, 700, 8388607, 1);
    run("t6", 60);
    chk("t6_first", qget(gnt_ord, 0), 0);
    chk("t6_second", qget(gnt_ord, 1), 2);
    chk("t6_val0", qget(res_v, 0), 700);
    chk("t6_val1", qget(res_v, 1), 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Round-robin arbiter and sequencer that shares one pipelined signed multiply-accumulate (MAC) unit among `NUM_REQ` FIR-style requesters. Typical requesters are the QPD input filters, the Hilbert transformer and the delay lines. Each requester streams one dot product as a burst of (data, coefficient) beats ending in a `last` beat. The block grants the MAC to one requester for a whole burst, computes the Q23-scaled, rounded and saturated result, and returns it tagged with the requester index.

## Interface
- `NUM_REQ`, default 4: number of requesters.
- `NUM_BITS`, default 24: operand and result width, signed.
- `ACC_BITS`, default 56: accumulator width, signed.
- `FRAC_BITS`, default 23: coefficient fraction bits; the result is the accumulator shifted right by this amount.

Ports, with `IW = $clog2(NUM_REQ)`:
- `clk_i` in 1: single clock; all logic on its rising edge.
- `reset_ni` in 1: asynchronous, active-low reset.
- `valid_i` in NUM_REQ: per-requester beat valid.
- `last_i` in NUM_REQ: per-requester final-beat flag, qualified by `valid_i`.
- `a_i` in NUM_REQ*NUM_BITS: packed signed data operands; requester k occupies bits [k*NUM_BITS +: NUM_BITS].
- `b_i` in NUM_REQ*NUM_BITS: packed signed coefficients, same packing as `a_i`.
- `ready_o` out NUM_REQ: beat accepted when `valid_i[k] & ready_o[k]`.
- `grant_o` out NUM_REQ: one-hot owner of the MAC; zero when idle.
- `result_o` out NUM_BITS: signed rounded and saturated dot product.
- `result_id_o` out IW: index of the requester that owns `result_o`.
- `result_valid_o` out 1: one-cycle pulse marking `result_o` and `result_id_o` valid.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, GRANT, BURST, DRAIN, OUT.
- **IDLE:** if any `valid_i` is high, select the first requester at or after `ptr+1`, modulo NUM_REQ, with `valid_i` high.
  - Register the selection as `grant_o`.
  - Next state is GRANT.
  - `ptr` resets to NUM_REQ-1, so requester 0 wins first.
- **GRANT:** one cycle. Set the `first` flag. Next state is BURST.
- **BURST:** `ready_o[g] = 1` for the granted index g only. `ready_o` is decoded combinationally from state and the grant register.
  - Each accepted beat loads stage 1 with `p = a*b`, a signed full 2*NUM_BITS product, together with `p_first` and `p_valid`.
  - Stage 2, when `p_valid` is set: if `p_first`, load `acc <= sext(p)`; otherwise `acc <= acc + sext(p)`. Clear `first` after the first accepted beat.
  - `valid_i[g]` low is a bubble: stay in BURST, no timeout, no preemption.
  - An accepted beat with `last_i[g]` high moves the FSM to DRAIN.
- **DRAIN:** wait for stage 1 and stage 2 to empty, which takes 2 cycles. Then register the result.
  - Round: `r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS`, arithmetic shift.
  - Saturate `r` to [-2^(NUM_BITS-1), 2^(NUM_BITS-1)-1].
  - Drive `result_o`, set `result_id_o = g`, set `ptr = g`. Next state is OUT.
- **OUT:** assert `result_valid_o` for one cycle and clear `grant_o`. Next state is IDLE.
- `result_o` and `result_id_o` hold their values until the next result.
- `valid_i` and `last_i` of non-granted requesters are ignored. Their `ready_o` stays 0, and they wait without losing their request.
- A single-beat burst (valid and last on the first beat) is legal. The result is `round_sat(a*b)`.
- Do not add a wrap/overflow check on `acc`. ACC_BITS=56 covers 2^8 full-scale beats.

## Timing
- Reset values:
  - `grant_o`=0, `ready_o`=0, `result_o`=0, `result_id_o`=0, `result_valid_o`=0, `busy_o`=0.
  - FSM in IDLE, `ptr`=NUM_REQ-1, pipeline valids cleared, `acc`=0.
- Reset may be asserted at any cycle, including mid-burst. The in-flight burst is discarded and no result pulse is produced.
- Request latency: `valid_i` high in IDLE at cycle t gives `grant_o` in t+1 and `ready_o` in t+2.
- Result latency: the last beat accepted at cycle t gives stage 1 at t+1, acc at t+2, result registered at t+3, and `result_valid_o` high during t+3 only.
- Throughput: one beat per cycle within a burst. Overhead is 5 cycles per burst (GRANT, 2×DRAIN, OUT, IDLE).
- Simultaneous requests are resolved by round-robin only. A requester that has just been served has the lowest priority next time.

## Test plan
- **Single-beat, unity gain:** requester 0 sends `a`=1000, `b`=8388607, `last`=1. Expect `result_o`=1000, `result_id_o`=0, `result_valid_o` exactly 3 cycles after acceptance.
- **Multi-beat, signed:** requester 2 sends 3 beats (4096, 4194304), (-2048, 4194304), (100, 8388607), the last beat with `last`. Expect `result_o`=1124, `result_id_o`=2.
- **Saturation:** 4 beats of (8388607, 8388607) give 8388607. 4 beats of (-8388608, 8388607) give -8388608.
- **Fairness:** all four requesters hold `valid_i` continuously with 2-beat bursts. Expect grant order 0,1,2,3,0,1 and no `ready_o` to a non-granted requester.
- **Bubbles:** the granted requester drops `valid_i` for 5 cycles mid-burst while requester 1 is valid. Expect no preemption, a correct sum, and requester 1 granted next.
- **Reset mid-burst:** pull `reset_ni` low during the 2nd beat. Expect all outputs at reset values immediately, no `result_valid_o`, and the first post-reset grant to go to requester 0.
